// File: rtl/uart_key_echo_if.sv
// ============================================================================
// Module   : uart_key_echo_if
// Purpose  : Serial pins and received-key bus of the UART keyboard front end.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_key_echo_if;
  logic       RX;
  logic       TX;
  logic [7:0] keys;

  modport master (output RX, input TX, input keys);
  modport slave  (input RX, output TX, output keys);
endinterface

`default_nettype wire

// File: rtl/uart_key_echo.sv
// ============================================================================
// Module   : uart_key_echo
// Purpose  : 8N1 UART receiver holding the last good byte on keys; the echo
//            transmitter is built only when UART_ECHO_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_key_echo #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  wire logic       CLK,
  input  wire logic       RESET,
  uart_key_echo_if.slave  bus
);

  localparam int                 c_DIV      = CLK_FREQ / (BAUD * 16);
  localparam int                 c_DIV_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic [c_DIV_W-1:0] r_div_cnt;
  logic               r_tick;

  logic               r_rx_meta;
  logic               r_rx_sync;

  state_t             r_rx_state;
  logic [3:0]         r_rx_tick_cnt;
  logic [2:0]         r_rx_bit_cnt;
  logic [7:0]         r_rx_shift;
  logic [7:0]         r_keys;
  logic               r_rx_wait_high;

  // Shared 16x oversampling tick for both directions.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (r_div_cnt == c_DIV_LAST) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
      r_tick    <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= bus.RX;
      r_rx_sync <= r_rx_meta;
    end
  end

`ifdef UART_ECHO_EN
  logic r_rx_done;
`endif

  // Wait-high is set out of reset so a line held low never looks like a start.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_rx_state     <= ST_IDLE;
      r_rx_tick_cnt  <= 4'd0;
      r_rx_bit_cnt   <= 3'd0;
      r_rx_shift     <= 8'h00;
      r_keys         <= 8'h00;
      r_rx_wait_high <= 1'b1;
`ifdef UART_ECHO_EN
      r_rx_done      <= 1'b0;
`endif
    end else begin
`ifdef UART_ECHO_EN
      r_rx_done <= 1'b0;
`endif
      case (r_rx_state)
        ST_IDLE: begin
          if (r_rx_wait_high) begin
            if (r_rx_sync) r_rx_wait_high <= 1'b0;
          end else if (!r_rx_sync) begin
            r_rx_tick_cnt <= 4'd0;
            r_rx_state    <= ST_START;
          end
        end
        ST_START: begin
          if (r_tick) begin
            if (r_rx_tick_cnt == 4'd7) begin
              r_rx_tick_cnt <= 4'd0;
              r_rx_bit_cnt  <= 3'd0;
              r_rx_state    <= r_rx_sync ? ST_IDLE : ST_DATA;
            end else begin
              r_rx_tick_cnt <= r_rx_tick_cnt + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (r_tick) begin
            if (r_rx_tick_cnt == 4'd15) begin
              r_rx_tick_cnt <= 4'd0;
              r_rx_shift    <= {r_rx_sync, r_rx_shift[7:1]};
              if (r_rx_bit_cnt == 3'd7) r_rx_state <= ST_STOP;
              else                      r_rx_bit_cnt <= r_rx_bit_cnt + 3'd1;
            end else begin
              r_rx_tick_cnt <= r_rx_tick_cnt + 4'd1;
            end
          end
        end
        ST_STOP: begin
          if (r_tick) begin
            if (r_rx_tick_cnt == 4'd15) begin
              r_rx_tick_cnt <= 4'd0;
              r_rx_state    <= ST_IDLE;
              if (r_rx_sync) begin
                r_keys    <= r_rx_shift;
`ifdef UART_ECHO_EN
                r_rx_done <= 1'b1;
`endif
              end else begin
                r_rx_wait_high <= 1'b1;
              end
            end else begin
              r_rx_tick_cnt <= r_rx_tick_cnt + 4'd1;
            end
          end
        end
        default: r_rx_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.keys = r_keys;

`ifdef UART_ECHO_EN
  state_t     r_tx_state;
  logic [3:0] r_tx_tick_cnt;
  logic [2:0] r_tx_bit_cnt;
  logic [7:0] r_tx_shift;
  logic [7:0] r_hold;
  logic       r_pending;
  logic       r_tx;

  // A new rx_done is applied after any load in the same cycle, so it wins.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tx_state    <= ST_IDLE;
      r_tx_tick_cnt <= 4'd0;
      r_tx_bit_cnt  <= 3'd0;
      r_tx_shift    <= 8'h00;
      r_hold        <= 8'h00;
      r_pending     <= 1'b0;
      r_tx          <= 1'b1;
    end else begin
      case (r_tx_state)
        ST_IDLE: begin
          if (r_tick && r_pending) begin
            r_tx          <= 1'b0;
            r_tx_shift    <= r_hold;
            r_pending     <= 1'b0;
            r_tx_tick_cnt <= 4'd0;
            r_tx_state    <= ST_START;
          end
        end
        ST_START: begin
          if (r_tick) begin
            if (r_tx_tick_cnt == 4'd15) begin
              r_tx_tick_cnt <= 4'd0;
              r_tx_bit_cnt  <= 3'd0;
              r_tx          <= r_tx_shift[0];
              r_tx_state    <= ST_DATA;
            end else begin
              r_tx_tick_cnt <= r_tx_tick_cnt + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (r_tick) begin
            if (r_tx_tick_cnt == 4'd15) begin
              r_tx_tick_cnt <= 4'd0;
              if (r_tx_bit_cnt == 3'd7) begin
                r_tx       <= 1'b1;
                r_tx_state <= ST_STOP;
              end else begin
                r_tx_bit_cnt <= r_tx_bit_cnt + 3'd1;
                r_tx         <= r_tx_shift[1];
                r_tx_shift   <= {1'b0, r_tx_shift[7:1]};
              end
            end else begin
              r_tx_tick_cnt <= r_tx_tick_cnt + 4'd1;
            end
          end
        end
        ST_STOP: begin
          if (r_tick) begin
            if (r_tx_tick_cnt == 4'd15) begin
              r_tx_tick_cnt <= 4'd0;
              // Chain straight into the next start bit when a byte is waiting.
              if (r_pending) begin
                r_tx       <= 1'b0;
                r_tx_shift <= r_hold;
                r_pending  <= 1'b0;
                r_tx_state <= ST_START;
              end else begin
                r_tx_state <= ST_IDLE;
              end
            end else begin
              r_tx_tick_cnt <= r_tx_tick_cnt + 4'd1;
            end
          end
        end
        default: r_tx_state <= ST_IDLE;
      endcase

      if (r_rx_done) begin
        r_hold    <= r_keys;
        r_pending <= 1'b1;
      end
    end
  end

  assign bus.TX = r_tx;
`else
  assign bus.TX = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_key_echo.sv
// ============================================================================
// Module   : tb_uart_key_echo
// Purpose  : Directed bench for uart_key_echo with a scoreboard of echoed bytes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_key_echo;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT_CLKS = 160;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  uart_key_echo_if bus();

  uart_key_echo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] q_echo[$];
  logic       tx_low_seen = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_bits(input int n);
    bus.RX = 1'b1;
    repeat (n * BIT_CLKS) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    bus.RX = 1'b0;
    repeat (BIT_CLKS) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      repeat (BIT_CLKS) @(negedge CLK);
    end
    bus.RX = stop;
    repeat (BIT_CLKS) @(negedge CLK);
    bus.RX = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
`ifdef UART_ECHO_EN
    q_echo.push_back(b);
`endif
    send_frame(b, 1'b1);
  endtask

  task automatic wait_drain(input string tag);
`ifdef UART_ECHO_EN
    for (int i = 0; i < 40 * BIT_CLKS; i++) begin
      if (q_echo.size() == 0) break;
      @(negedge CLK);
    end
    chk(tag, 8'(q_echo.size()), 8'd0);
`else
    chk(tag, {7'd0, tx_low_seen}, 8'd0);
`endif
  endtask

  // TX monitor: decode echoed frames, or note any departure from idle-high.
  initial begin : tx_monitor
    logic [7:0] d;
    logic       st;
    logic [7:0] exp;
    forever begin
      @(negedge CLK);
`ifdef UART_ECHO_EN
      if (!RESET && bus.TX === 1'b0) begin
        repeat (BIT_CLKS / 2) @(negedge CLK);
        st = bus.TX;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CLKS) @(negedge CLK);
          d[i] = bus.TX;
        end
        repeat (BIT_CLKS) @(negedge CLK);
        chk("echo_start", {7'd0, st}, 8'd0);
        chk("echo_stop", {7'd0, bus.TX}, 8'd1);
        if (q_echo.size() == 0) begin
          total++;
          bad++;
          $error("FAIL echo_unexpected observed=%h expected=none", d);
        end else begin
          exp = q_echo.pop_front();
          chk("echo_byte", d, exp);
        end
      end
`else
      if (bus.TX !== 1'b1) tx_low_seen = 1'b1;
`endif
    end
  end

  initial begin
    logic [7:0] b2b[4];
    b2b[0] = 8'h57; b2b[1] = 8'h41; b2b[2] = 8'h53; b2b[3] = 8'h44;

    bus.RX = 1'b1;
    RESET  = 1'b1;
    repeat (5) @(negedge CLK);
    chk("reset_keys", bus.keys, 8'h00);
    chk("reset_tx", {7'd0, bus.TX}, 8'd1);
    RESET = 1'b0;
    idle_bits(2);
    chk("idle_keys", bus.keys, 8'h00);

    send_good(8'h41);
    chk("single_keys", bus.keys, 8'h41);

    send_frame(8'h55, 1'b0);
    idle_bits(2);
    chk("ferr_keys", bus.keys, 8'h41);

    send_good(8'h5A);
    chk("after_ferr_keys", bus.keys, 8'h5A);
    idle_bits(12);
    chk("pre_glitch_tx", {7'd0, bus.TX}, 8'd1);

    bus.RX = 1'b0;
    repeat (60) @(negedge CLK);
    idle_bits(3);
    chk("glitch_keys", bus.keys, 8'h5A);
    chk("glitch_tx", {7'd0, bus.TX}, 8'd1);

    for (int i = 0; i < 4; i++) begin
      send_good(b2b[i]);
      chk("b2b_keys", bus.keys, b2b[i]);
    end
    idle_bits(2);
    wait_drain("b2b_drain");

    repeat (BIT_CLKS) @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("midsim_reset_keys", bus.keys, 8'h00);
    chk("midsim_reset_tx", {7'd0, bus.TX}, 8'd1);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    idle_bits(3);
    chk("post_reset_keys", bus.keys, 8'h00);
    chk("post_reset_tx", {7'd0, bus.TX}, 8'd1);

    send_good(8'h44);
    chk("final_keys", bus.keys, 8'h44);
    idle_bits(2);
    wait_drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
